// File: rtl/ron_pkg.sv
// Shared types and constants for the ron register file.
package ron_pkg;

    localparam int unsigned DataWDef = 8;
    localparam int unsigned DepthDef = 16;

    // CLEAR: post-reset zeroing sweep; RUN: normal read/write operation.
    typedef enum logic [0:0] {
        StClear,
        StRun
    } ron_state_e;

    // Address width needed to index a register file of the given depth.
    function automatic int unsigned addr_w_of(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ron_lock_sb.sv
// Per-register lock scoreboard: one bit per register marking a pending
// multi-cycle result. Lookups see the state before the current edge.
module ron_lock_sb
    import ron_pkg::*;
#(
    parameter int unsigned DEPTH  = DepthDef,
    parameter int unsigned ADDR_W = addr_w_of(DEPTH)
) (
    input  logic              c,
    input  logic              clr_all,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_a,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_a,
    input  logic [ADDR_W-1:0] look_x,
    input  logic [ADDR_W-1:0] look_y,
    output logic              hit_x,
    output logic              hit_y
);

    logic [DEPTH-1:0] lock_q;
    logic [DEPTH-1:0] lock_d;

    // Next lock vector: release by write, then set (set wins on collision).
    always_comb begin
        lock_d = lock_q;
        if (clr_en) begin
            lock_d[clr_a] = 1'b0;
        end
        if (set_en) begin
            lock_d[set_a] = 1'b1;
        end
        if (clr_all) begin
            lock_d = '0;
        end
    end

    // Lock vector register.
    always_ff @(posedge c) begin
        lock_q <= lock_d;
    end

    // Lookups of the pre-edge state.
    always_comb begin
        hit_x = lock_q[look_x];
        hit_y = lock_q[look_y];
    end

endmodule

// File: rtl/ron_file.sv
// Register file with two registered read ports, one write port with
// same-cycle bypass, a lock scoreboard and a post-reset clear sweep.
module ron_file
    import ron_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDef,
    parameter int unsigned DEPTH  = DepthDef,
    parameter int unsigned ADDR_W = addr_w_of(DEPTH)
) (
    input  logic              c,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra_x,
    input  logic [ADDR_W-1:0] ra_y,
    input  logic              zero_y,
    input  logic              lock_en,
    input  logic [ADDR_W-1:0] lock_a,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic              stall_x,
    output logic              stall_y,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    ron_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clr_wr;
    logic              run;

    logic [DATA_W-1:0] ron_q [DEPTH];

    logic [DATA_W-1:0] x_q, y_q;
    logic              stall_x_q, stall_y_q;

    logic              wr_en;
    logic              byp_x, byp_y;
    logic              lock_hit_x, lock_hit_y;

    // Next-state logic: sweep addresses during CLEAR, then settle in RUN.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_wr    = 1'b0;
        run       = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_wr    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LastAddr) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                end
            end
            StRun: begin
                run = 1'b1;
            end
            default: begin
                state_d   = StClear;
                clr_cnt_d = '0;
            end
        endcase
    end

    // State and sweep counter registers.
    always_ff @(posedge c) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Writes and bypass only exist in RUN; a reset cycle drops everything.
    always_comb begin
        wr_en = run && we && !rst;
        byp_x = wr_en && (wa == ra_x);
        byp_y = wr_en && (wa == ra_y);
    end

    // Storage array: sweep zeros during CLEAR, normal writes in RUN.
    always_ff @(posedge c) begin
        if (!rst) begin
            if (clr_wr) begin
                ron_q[clr_cnt_q] <= '0;
            end else if (wr_en) begin
                ron_q[wa] <= wd;
            end
        end
    end

    ron_lock_sb #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_lock_sb (
        .c       (c),
        .clr_all (rst),
        .set_en  (run && lock_en),
        .set_a   (lock_a),
        .clr_en  (wr_en),
        .clr_a   (wa),
        .look_x  (ra_x),
        .look_y  (ra_y),
        .hit_x   (lock_hit_x),
        .hit_y   (lock_hit_y)
    );

    // Registered read ports; held at zero during reset and the sweep.
    always_ff @(posedge c) begin
        if (rst || !run) begin
            x_q       <= '0;
            y_q       <= '0;
            stall_x_q <= 1'b0;
            stall_y_q <= 1'b0;
        end else begin
            x_q       <= byp_x ? wd : ron_q[ra_x];
            stall_x_q <= lock_hit_x && !byp_x;
            if (zero_y) begin
                y_q       <= '0;
                stall_y_q <= 1'b0;
            end else begin
                y_q       <= byp_y ? wd : ron_q[ra_y];
                stall_y_q <= lock_hit_y && !byp_y;
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        x       = x_q;
        y       = y_q;
        stall_x = stall_x_q;
        stall_y = stall_y_q;
        busy    = (state_q == StClear);
    end

endmodule

// File: tb/tb_ron_file.sv
module tb_ron_file;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AW = 4;

    logic          c = 1'b0;
    logic          rst, we, zero_y, lock_en;
    logic [AW-1:0] wa, ra_x, ra_y, lock_a;
    logic [DW-1:0] wd;
    logic [DW-1:0] x, y;
    logic          stall_x, stall_y, busy;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DW-1:0] m_ron [DP];
    bit            m_lock [DP];
    int            m_clear_left = 0;
    logic [DW-1:0] e_x = '0, e_y = '0;
    logic          e_sx = 1'b0, e_sy = 1'b0, e_busy = 1'b1;

    ron_file #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .c       (c),
        .rst     (rst),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra_x    (ra_x),
        .ra_y    (ra_y),
        .zero_y  (zero_y),
        .lock_en (lock_en),
        .lock_a  (lock_a),
        .x       (x),
        .y       (y),
        .stall_x (stall_x),
        .stall_y (stall_y),
        .busy    (busy)
    );

    always #5 c = ~c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input bit r, input bit w, input int a, input int d,
                        input int rx, input int ry, input bit zy,
                        input bit le, input int la);
        rst = r; we = w; wa = AW'(a); wd = DW'(d);
        ra_x = AW'(rx); ra_y = AW'(ry); zero_y = zy;
        lock_en = le; lock_a = AW'(la);
        @(posedge c);
        if (r) begin
            m_clear_left = DP;
            foreach (m_lock[i]) m_lock[i] = 0;
            e_x = '0; e_y = '0; e_sx = 0; e_sy = 0; e_busy = 1;
        end else if (m_clear_left > 0) begin
            m_ron[DP - m_clear_left] = '0;
            m_clear_left--;
            e_x = '0; e_y = '0; e_sx = 0; e_sy = 0;
            e_busy = (m_clear_left != 0);
        end else begin
            e_busy = 0;
            e_x  = (w && a == rx) ? DW'(d) : m_ron[rx];
            e_sx = m_lock[rx] && !(w && a == rx);
            if (zy) begin
                e_y = '0; e_sy = 0;
            end else begin
                e_y  = (w && a == ry) ? DW'(d) : m_ron[ry];
                e_sy = m_lock[ry] && !(w && a == ry);
            end
            if (w) begin
                m_ron[a] = DW'(d);
                m_lock[a] = 0;
            end
            if (le) m_lock[la] = 1;
        end
        #1;
        chk("x", 32'(x), 32'(e_x));
        chk("y", 32'(y), 32'(e_y));
        chk("stall_x", 32'(stall_x), 32'(e_sx));
        chk("stall_y", 32'(stall_y), 32'(e_sy));
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic idle(input int rx, input int ry);
        step(0, 0, 0, 0, rx, ry, 0, 0, 0);
    endtask

    initial begin
        foreach (m_ron[i]) m_ron[i] = 'x;
        foreach (m_lock[i]) m_lock[i] = 0;

        // Reset pulse, then a 16-cycle sweep.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_x", 32'(x), 32'd0);
        for (int i = 0; i < DP - 1; i++) idle(0, 0);
        chk("busy_edge15", 32'(busy), 32'd1);
        idle(0, 0);
        chk("busy_edge16", 32'(busy), 32'd0);

        // All registers cleared.
        for (int i = 0; i < DP; i++) idle(i, DP - 1 - i);

        // Write with bypass, then read back on Y.
        step(0, 1, 3, 'hA5, 3, 0, 0, 0, 0);
        chk("bypass_x", 32'(x), 32'hA5);
        idle(0, 3);
        chk("read_y", 32'(y), 32'hA5);

        // zero_y forces Y to zero.
        step(0, 1, 5, 'h3C, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 5, 5, 1, 0, 0);
        chk("zy_x", 32'(x), 32'h3C);
        chk("zy_y", 32'(y), 32'h00);
        chk("zy_sy", 32'(stall_y), 32'd0);

        // Lock then release through a bypassed write.
        step(0, 0, 0, 0, 0, 0, 0, 1, 7);
        idle(7, 7);
        chk("lock_sx", 32'(stall_x), 32'd1);
        chk("lock_sy", 32'(stall_y), 32'd1);
        step(0, 1, 7, 'h11, 7, 0, 0, 0, 0);
        chk("rel_x", 32'(x), 32'h11);
        chk("rel_sx", 32'(stall_x), 32'd0);

        // Lock and write collide: data written, lock remains.
        step(0, 1, 2, 'h55, 0, 0, 0, 1, 2);
        idle(2, 0);
        chk("coll_x", 32'(x), 32'h55);
        chk("coll_sx", 32'(stall_x), 32'd1);

        // Reset mid-sweep; writes during busy are ignored.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) idle(0, 0);
        step(1, 1, 0, 'hFF, 0, 0, 0, 0, 0);
        for (int i = 0; i < DP - 1; i++) step(0, 1, 0, 'hFF, 0, 0, 0, 1, 0);
        chk("mid_busy15", 32'(busy), 32'd1);
        step(0, 1, 0, 'hFF, 0, 0, 0, 1, 0);
        chk("mid_busy16", 32'(busy), 32'd0);
        idle(0, 2);
        chk("mid_r0", 32'(x), 32'h00);
        chk("mid_sx", 32'(stall_x), 32'd0);
        chk("mid_r2", 32'(y), 32'h00);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, DP - 1), $urandom_range(0, 255),
                 $urandom_range(0, DP - 1), $urandom_range(0, DP - 1),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, DP - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ron_file.md
# ron_file

Parametrised general-purpose register file with two registered read ports, one write port, and same-cycle write-to-read bypass. It adds a per-register lock scoreboard for multi-cycle producers and a post-reset clear sweep. The block sits between the instruction decoder, which supplies explicit addresses, and the ALU/data bus. It replaces fixed 16×8 register storage and keeps the opcode decode in the decoder.

## Interface
- DATA_W, 8, register width in bits
- DEPTH, 16, number of registers (power of two, ≥2)
- ADDR_W, 4, address width, must equal log2(DEPTH)
- c  in  1  clock; all state changes on posedge c
- rst  in  1  reset; one clock, synchronous, active-high
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data (from d_bus)
- ra_x  in  ADDR_W  read address, port X
- ra_y  in  ADDR_W  read address, port Y
- zero_y  in  1  force port Y result to 0 (single-operand / immediate ops)
- lock_en  in  1  mark register lock_a as awaiting a multi-cycle result
- lock_a  in  ADDR_W  register to lock
- x  out  DATA_W  port X data, registered
- y  out  DATA_W  port Y data, registered
- stall_x  out  1  registered; X read hit a locked register
- stall_y  out  1  registered; Y read hit a locked register (0 when zero_y)
- busy  out  1  clear sweep in progress; all inputs except rst ignored

## Operation
- FSM states: CLEAR, RUN. rst → CLEAR, clr_cnt=0, all lock bits=0.
- CLEAR: each cycle writes 0 to ron[clr_cnt], clr_cnt++; at clr_cnt==DEPTH-1 the write happens and the state goes to RUN next cycle. busy=1 throughout. we/lock_en are ignored, and x=y=0 with stall_x=stall_y=0.
- RUN: busy=0.
  - Write: if we, ron[wa]←wd at posedge and lock[wa]←0.
  - Lock: if lock_en, lock[lock_a]←1. If lock_en and we target the same register in the same cycle, the data is written and the lock bit ends at 1 (lock wins).
  - Read X: x←(we && wa==ra_x) ? wd : ron[ra_x]. stall_x←lock[ra_x] && !(we && wa==ra_x).
  - Read Y: same rule with ra_y. When zero_y=1: y←0 and stall_y←0.
  - Lock bits are read as they were before this edge, so a lock set in cycle N stalls reads presented from cycle N+1 on.
- rst asserted during CLEAR or RUN restarts CLEAR from register 0. Any in-flight write in that cycle is discarded.

## Timing
- Reset values: x=0, y=0, stall_x=0, stall_y=0, busy=1 (from the first edge with rst=1).
- Clear sweep: DEPTH cycles after rst deasserts. busy falls on edge DEPTH after the last rst cycle.
- Read latency: 1 cycle. Address at edge N gives data valid after edge N.
- Write latency: 0 cycles to the read ports through the bypass. The array updates at the same edge.
- Lock: takes effect on stall outputs for reads issued the cycle after lock_en. The releasing write is visible through the bypass in its own cycle.
- No combinational path from inputs to outputs.

## Structure
- Shared package ron_pkg: state enum {CLEAR, RUN}, default DATA_W/DEPTH constants, and the helper function for ADDR_W.
- One natural sub-module, ron_lock_sb: DEPTH-bit lock vector with set/clear/clear-all ports and two lookup ports. Array, bypass and FSM stay in the top module.

## Test plan
- Reset/clear: pulse rst for 1 cycle → busy=1 for 16 cycles, then 0. Read all 16 registers → every x=y=0x00.
- Write/read plus bypass: we=1, wa=3, wd=0xA5, ra_x=3 in the same cycle → x=0xA5 after that edge. Next cycle ra_y=3 → y=0xA5.
- zero_y: ron[5]=0x3C, ra_x=5, ra_y=5, zero_y=1 → x=0x3C, y=0x00, stall_y=0.
- Lock/release: lock_en with lock_a=7. Next cycle read ra_x=7 → stall_x=1. Then we=1, wa=7, wd=0x11, ra_x=7 in the same cycle → x=0x11, stall_x=0.
- Lock-vs-write collision: lock_en, lock_a=2, we=1, wa=2, wd=0x55 in the same cycle → ron[2]=0x55, and the next read of 2 gives stall_x=1.
- Reset mid-sweep and writes during busy: rst at clear cycle 6 → busy lasts 16 more cycles. we=1, wa=0, wd=0xFF during busy → ron[0] reads 0x00 afterward.
